// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
// Control-vector layout: ALU_Src, Branch, MemRd, MemToReg, MemWr, RegWr, jal, jalr (bit 0 upward).
package hazard_pkg;

  localparam int unsigned CTRL_W_DEF  = 8;
  localparam int unsigned REG_AW_DEF  = 5;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned PERF_W      = 32;

  localparam int unsigned CTRL_ALU_SRC = 0;
  localparam int unsigned CTRL_BRANCH  = 1;
  localparam int unsigned CTRL_MEMRD   = 2;
  localparam int unsigned CTRL_MEM2REG = 3;
  localparam int unsigned CTRL_MEMWR   = 4;
  localparam int unsigned CTRL_REGWR   = 5;
  localparam int unsigned CTRL_JAL     = 6;
  localparam int unsigned CTRL_JALR    = 7;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  // Counter preload for a multi-cycle window: the entry cycle itself is the first one.
  function automatic logic [CNT_W-1:0] cnt_init(input int unsigned cycles);
    return (cycles > 1) ? CNT_W'(cycles - 2) : '0;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter for hazard performance monitoring.
module hazard_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID/EX hazard controller: load-use stall, redirect flush, ID/EX control register.
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CTRL_W         = CTRL_W_DEF,
  parameter int unsigned REG_AW         = REG_AW_DEF,
  parameter int unsigned MEMREAD_BIT    = CTRL_MEMRD,
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned FLUSH_CYC      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              redirect_i,
  input  logic              ext_stall_i,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic              bubble_o,
  output logic [CTRL_W-1:0] ex_ctrl_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] STALL_INIT = cnt_init(LOAD_STALL_CYC);
  localparam logic [CNT_W-1:0] FLUSH_INIT = cnt_init(FLUSH_CYC);

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic              lu_hit_c;

  // Writes to x0 never create a dependency.
  assign lu_hit_c = ex_ctrl_q[MEMREAD_BIT] && (ex_rd_i != '0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ex_ctrl_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_ctrl_q <= ex_ctrl_d;
    end
  end

  // Priority: freeze > redirect > load-use stall > flush tail > normal.
  always_comb begin
    pc_we_o      = 1'b1;
    ifid_we_o    = 1'b1;
    ifid_flush_o = 1'b0;
    bubble_o     = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    ex_ctrl_d    = ex_ctrl_q;

    if (ext_stall_i) begin
      pc_we_o   = 1'b0;
      ifid_we_o = 1'b0;
    end else begin
      if (redirect_i) begin
        ifid_flush_o = 1'b1;
        bubble_o     = 1'b1;
        state_d      = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
        cnt_d        = FLUSH_INIT;
      end else if ((state_q == ST_LU_STALL) || ((state_q == ST_RUN) && lu_hit_c)) begin
        pc_we_o   = 1'b0;
        ifid_we_o = 1'b0;
        bubble_o  = 1'b1;
        if (state_q == ST_RUN) begin
          state_d = (LOAD_STALL_CYC > 1) ? ST_LU_STALL : ST_RUN;
          cnt_d   = STALL_INIT;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (state_q == ST_FLUSH) begin
        ifid_flush_o = 1'b1;
        bubble_o     = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ex_ctrl_d = bubble_o ? '0 : id_ctrl_i;
    end
  end

  assign ex_ctrl_o = ex_ctrl_q;

`ifdef HAZ_PERF_CNT_EN
  logic stall_inc_c;
  logic flush_inc_c;

  // Unfrozen cycles with pc_we low can only come from a load-use stall.
  assign stall_inc_c = !ext_stall_i && !pc_we_o;
  assign flush_inc_c = !ext_stall_i && ifid_flush_o;

  hazard_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (stall_inc_c),
    .cnt_o (stall_cnt_o)
  );

  hazard_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (flush_inc_c),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule
